// File: rtl/dm_byte_mem_if.sv
// Request/response bus for the byte-addressable data memory.
// The master issues loads/stores; the slave answers one cycle after accept.
interface dm_byte_mem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sext;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dm_byte_mem.sv
// Word-organised data memory with byte/half/word access, one-cycle registered
// responses, and a self-clearing sequence that zeroes every word after reset.
module dm_byte_mem #(
    parameter int WORDS  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    dm_byte_mem_if.slave   bus
);
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [IDX_W-1:0]  clr_idx_r;
    logic [31:0]       mem_r [WORDS];

    logic [ADDR_W-3:0] word_addr_s;
    logic [IDX_W-1:0]  word_idx_s;
    logic [1:0]        lane_s;
    logic              size_err_s;
    logic              range_err_s;
    logic              err_s;
    logic              accept_s;
    logic              wr_en_s;
    logic [3:0]        wmask_s;
    logic [31:0]       wdata_rep_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       rd_shift_s;
    logic [31:0]       rd_data_s;
    logic [31:0]       merged_s;

    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [31:0]       rsp_rdata_r;

    function automatic logic [31:0] extend8(input logic [7:0] b, input logic sext);
        return sext ? {{24{b[7]}}, b} : {24'h000000, b};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] h, input logic sext);
        return sext ? {{16{h[15]}}, h} : {16'h0000, h};
    endfunction

    assign bus.req_ready = (state_r == ST_IDLE) && !reset;
    assign bus.busy      = (state_r == ST_CLEAR);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign accept_s      = bus.req_valid && bus.req_ready;
    assign wr_en_s       = accept_s && bus.req_we && !err_s;

    // Address decode, legality check, load extraction and store byte merge
    always_comb begin
        word_addr_s = bus.req_addr[ADDR_W-1:2];
        word_idx_s  = word_addr_s[IDX_W-1:0];
        lane_s      = bus.req_addr[1:0];
        rd_word_s   = mem_r[word_idx_s];
        rd_shift_s  = rd_word_s >> {lane_s, 3'b000};
        size_err_s  = 1'b0;
        wmask_s     = 4'b0000;
        wdata_rep_s = 32'h0000_0000;
        rd_data_s   = 32'h0000_0000;
        merged_s    = rd_word_s;
        case (bus.req_size)
            2'b00: begin
                wmask_s     = 4'b0001 << lane_s;
                wdata_rep_s = {4{bus.req_wdata[7:0]}};
                rd_data_s   = extend8(rd_shift_s[7:0], bus.req_sext);
            end
            2'b01: begin
                size_err_s  = lane_s[0];
                wmask_s     = lane_s[1] ? 4'b1100 : 4'b0011;
                wdata_rep_s = {2{bus.req_wdata[15:0]}};
                rd_data_s   = extend16(rd_shift_s[15:0], bus.req_sext);
            end
            2'b10: begin
                size_err_s  = (lane_s != 2'b00);
                wmask_s     = 4'b1111;
                wdata_rep_s = bus.req_wdata;
                rd_data_s   = rd_word_s;
            end
            default: begin
                size_err_s  = 1'b1;
            end
        endcase
        // Compare the full word address so high bits cannot alias onto low words
        range_err_s = (word_addr_s >= (ADDR_W-2)'(WORDS));
        err_s       = size_err_s || range_err_s;
        for (int i = 0; i < 4; i++) begin
            if (wmask_s[i]) begin
                merged_s[8*i +: 8] = wdata_rep_s[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = rd_word_s[8*i +: 8];
            end
        end
    end

    // Clear/idle state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Leave the clear state once the last word has been zeroed
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_idx_r == IDX_W'(WORDS - 1)) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_CLEAR;
                end
            end
            ST_IDLE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_CLEAR;
        endcase
    end

    // Clear index walks 0..WORDS-1 while clearing, held at zero otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_idx_r <= '0;
        end else if (state_r == ST_CLEAR) begin
            clr_idx_r <= clr_idx_r + IDX_W'(1);
        end else begin
            clr_idx_r <= '0;
        end
    end

    // Storage: clearing has priority; stores cannot be accepted while clearing
    always_ff @(posedge clk) begin
        if (!reset && state_r == ST_CLEAR) begin
            mem_r[clr_idx_r] <= 32'h0000_0000;
        end else if (wr_en_s) begin
            mem_r[word_idx_s] <= merged_s;
        end
    end

    // Registered one-cycle response; data is zero for stores and errors
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (err_s || bus.req_we) ? 32'h0000_0000 : rd_data_s;
        end else begin
            rsp_valid_r <= 1'b0;
        end
    end
endmodule

// File: doc/dm_byte_mem.md
DM_BYTE_MEM -- requirements
Module: dm_byte_mem

Interface
REQ-001 Parameter WORDS, 1024, number of 32-bit words stored; SHALL be a power of two >= 4.
REQ-002 Parameter ADDR_W, 32, width of the byte address port.
REQ-003 Port clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid  input  1  request present this cycle.
REQ-006 Port req_ready  output  1  block can accept a request; SHALL equal !busy && !reset (combinational).
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 Port req_sext  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-010 Port req_addr  input  ADDR_W  byte address.
REQ-011 Port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port rsp_valid  output  1  one-cycle response pulse.
REQ-013 Port rsp_rdata  output  32  load result, registered.
REQ-014 Port rsp_err  output  1  request rejected (misaligned, illegal size, out of range).
REQ-015 Port busy  output  1  clear sequence in progress.

Function
REQ-016 Accept SHALL occur when req_valid && req_ready at a rising edge; throughput one request per cycle.
REQ-017 Every accepted request SHALL produce exactly one rsp_valid pulse in the following cycle (latency 1); loads and stores both respond.
REQ-018 Error SHALL be flagged when req_size==11, or half with addr[0]!=0, or word with addr[1:0]!=0, or addr[ADDR_W-1:2] >= WORDS.
REQ-019 On error: no memory change, rsp_err=1, rsp_rdata=0.
REQ-020 Store byte SHALL write req_wdata[7:0] into lane addr[1:0] of word addr[ADDR_W-1:2]; the other three bytes SHALL remain unchanged.
REQ-021 Store half SHALL write req_wdata[15:0] into lanes {addr[1],0} and {addr[1],1}; other bytes unchanged.
REQ-022 Store word SHALL write all 32 bits.
REQ-023 Store response: rsp_rdata=0, rsp_err=0.
REQ-024 Load SHALL extract the addressed byte/half (little-endian lanes) and extend it to 32 bits per req_sext; req_sext SHALL be ignored for words.
REQ-025 A load accepted in the cycle after a store to the same word SHALL return the updated data.
REQ-026 Requests presented while req_ready=0 SHALL be ignored, with no response and no memory change.
REQ-027 Clear sequence: while busy, one word per cycle SHALL be zeroed in ascending index order 0..WORDS-1 by an internal counter.
REQ-028 busy SHALL fall in the cycle after word WORDS-1 is cleared, so it stays high exactly WORDS cycles after reset deasserts.

Reset
REQ-029 At a rising edge with reset=1: busy<=1, clear counter<=0, rsp_valid<=0, rsp_rdata<=0, rsp_err<=0.
REQ-030 While reset is held, the clear counter SHALL remain 0.
REQ-031 Reset asserted mid-clear or mid-response SHALL restart the clear from index 0 and drop any pending response.
REQ-032 Memory contents SHALL be all-zero once busy falls.

Verification (WORDS=16)
REQ-033 Reset 1 cycle, then idle -> busy high exactly 16 cycles, req_ready low throughout, then all 16 words load 0.
REQ-034 sw 0x8899AABB @0x4, then lb @0x5 sext=1 -> rsp 0xFFFFFFAA next cycle; lhu @0x6 -> 0x00008899.
REQ-035 sw 0x11223344 @0x8, sb 0xEE @0xA, lw @0x8 -> 0x11EE3344; back-to-back requests give 3 consecutive rsp_valid pulses.
REQ-036 lh @0x3, lw @0x2, size 11 @0x0, lw @0x40 -> each rsp_err=1, rsp_rdata=0; sw @0x42 leaves memory unchanged.
REQ-037 Reset reasserted 5 cycles into the clear, after a prior sw 0xFFFFFFFF @0x3C -> busy held 16 further cycles after release; lw @0x3C returns 0.
REQ-038 req_valid=1 while busy -> no rsp_valid, no memory write.
